// File: rtl/stream_extremum_finder.sv
`default_nettype none
// ============================================================================
// Module   : stream_extremum_finder
// Purpose  : Scans FRAME_LEN samples from a valid/ready stream. It reports the
//            frame maximum or minimum and the index where that value first
//            appears. Comparison is unsigned or two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module stream_extremum_finder #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4,
  parameter bit SIGNED    = 1'b0,
  parameter int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mode_min,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] res_val,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_mode,
  output logic             out_valid
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ACCUM = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;
  localparam int         c_LAST  = FRAME_LEN - 1;

  logic [1:0]       state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] res_val_q, res_val_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic             res_mode_q, res_mode_d;

  logic w_gt;
  logic w_lt;
  logic w_better;
  logic w_last;

  // Sample-versus-best ordering, chosen once by the SIGNED parameter.
  generate
    if (SIGNED) begin : g_signed
      assign w_gt = $signed(in_data) > $signed(best_q);
      assign w_lt = $signed(in_data) < $signed(best_q);
    end else begin : g_unsigned
      assign w_gt = in_data > best_q;
      assign w_lt = in_data < best_q;
    end
  endgenerate

  // Strict comparison only, so ties keep the earliest index.
  assign w_better = mode_q ? w_lt : w_gt;
  assign w_last   = (cnt_q == c_LAST[IDX_W:0]);

  assign in_ready  = (state_q != c_DONE);
  assign busy      = (state_q == c_ACCUM);
  assign out_valid = (state_q == c_DONE);
  assign res_val   = res_val_q;
  assign res_idx   = res_idx_q;
  assign res_mode  = res_mode_q;

  // Next-state logic: clear outranks in_valid, and DONE always publishes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    mode_d     = mode_q;
    res_val_d  = res_val_q;
    res_idx_d  = res_idx_q;
    res_mode_d = res_mode_q;
    case (state_q)
      c_IDLE: begin
        if (clear) begin
          cnt_d = '0;
        end else if (in_valid) begin
          best_d     = in_data;
          best_idx_d = '0;
          cnt_d      = {{IDX_W{1'b0}}, 1'b1};
          mode_d     = mode_min;
          if (FRAME_LEN == 1) begin
            // A one-sample frame is complete as soon as it is accepted.
            state_d    = c_DONE;
            res_val_d  = in_data;
            res_idx_d  = '0;
            res_mode_d = mode_min;
          end else begin
            state_d = c_ACCUM;
          end
        end
      end
      c_ACCUM: begin
        if (clear) begin
          state_d = c_IDLE;
          cnt_d   = '0;
        end else if (in_valid) begin
          if (w_better) begin
            best_d     = in_data;
            best_idx_d = cnt_q[IDX_W-1:0];
          end
          cnt_d = cnt_q + 1'b1;
          if (w_last) begin
            // Publish the post-update best so the result is visible in DONE.
            state_d    = c_DONE;
            res_val_d  = w_better ? in_data : best_q;
            res_idx_d  = w_better ? cnt_q[IDX_W-1:0] : best_idx_q;
            res_mode_d = mode_q;
          end
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_IDLE;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      mode_q     <= 1'b0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
      res_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      mode_q     <= mode_d;
      res_val_q  <= res_val_d;
      res_idx_q  <= res_idx_d;
      res_mode_q <= res_mode_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_extremum_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_extremum_finder
// Purpose  : Scoreboard bench for stream_extremum_finder. Unsigned and signed
//            4x4 instances share one stimulus stream. A separate 8-bit,
//            one-sample-per-frame instance is also exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_extremum_finder;

  localparam int FL = 4;

  typedef struct packed {
    logic [7:0] v;
    logic [1:0] i;
    logic       m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       mode_min = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;

  logic       rdy_u, busy_u, mode_u, ov_u;
  logic [3:0] val_u;
  logic [1:0] idx_u;
  logic       rdy_s, busy_s, mode_s, ov_s;
  logic [3:0] val_s;
  logic [1:0] idx_s;

  logic       clear1 = 1'b0;
  logic       mode_min1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1 = 8'd0;
  logic       rdy1, busy1, mode1, ov1;
  logic [7:0] val1;
  logic [0:0] idx1;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_u[$];
  exp_t exp_s[$];
  exp_t exp_1[$];
  exp_t last_u, last_s;
  exp_t eu, es, e1;
  int   cur_q[$];
  logic cur_m;

  always #5 clk = ~clk;

  stream_extremum_finder #(.WIDTH(4), .FRAME_LEN(4), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode_min(mode_min),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_u), .busy(busy_u),
    .res_val(val_u), .res_idx(idx_u), .res_mode(mode_u), .out_valid(ov_u)
  );

  stream_extremum_finder #(.WIDTH(4), .FRAME_LEN(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode_min(mode_min),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_s), .busy(busy_s),
    .res_val(val_s), .res_idx(idx_s), .res_mode(mode_s), .out_valid(ov_s)
  );

  stream_extremum_finder #(.WIDTH(8), .FRAME_LEN(1), .SIGNED(1'b0)) u_dut_1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .mode_min(mode_min1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(rdy1), .busy(busy1),
    .res_val(val1), .res_idx(idx1), .res_mode(mode1), .out_valid(ov1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: pick the extreme value, then the first position holding it.
  function automatic exp_t ref_result(input bit sgn);
    int   vals[FL];
    int   ext;
    int   idx;
    exp_t r;
    for (int i = 0; i < FL; i++)
      vals[i] = (sgn && cur_q[i] >= 8) ? cur_q[i] - 16 : cur_q[i];
    ext = vals[0];
    for (int i = 1; i < FL; i++) begin
      if (cur_m) ext = (vals[i] < ext) ? vals[i] : ext;
      else       ext = (vals[i] > ext) ? vals[i] : ext;
    end
    idx = 0;
    for (int i = FL - 1; i >= 0; i--)
      if (vals[i] == ext) idx = i;
    r.v = 8'(ext & 15);
    r.i = 2'(idx);
    r.m = cur_m;
    return r;
  endfunction

  task automatic model_accept(input logic [3:0] d, input logic m, output bit done);
    if (cur_q.size() == 0) cur_m = m;
    cur_q.push_back(int'(d));
    done = (cur_q.size() == FL);
    if (done) begin
      exp_u.push_back(ref_result(1'b0));
      exp_s.push_back(ref_result(1'b1));
      cur_q.delete();
    end
  endtask

  // Offer one sample, wait for acceptance, then idle for 'gap' cycles.
  task automatic send(input logic [3:0] d, input logic m, input int gap);
    int t;
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    mode_min = m;
    t = 0;
    while (!rdy_u && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", rdy_u, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    mode_min = 1'($urandom);
    model_accept(d, m, done);
    chk("latency_ov", ov_u, done);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("gap_busy", busy_u, (cur_q.size() != 0));
    end
  endtask

  task automatic do_clear();
    in_valid = 1'b1;
    in_data  = 4'($urandom);
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    cur_q.delete();
    chk("clr_busy", busy_u, 0);
    chk("clr_ov", ov_u, 0);
    chk("clr_val_u", val_u, last_u.v);
    chk("clr_idx_u", idx_u, last_u.i);
    chk("clr_val_s", val_s, last_s.v);
  endtask

  // Scoreboard monitors: pop one expectation per out_valid pulse.
  always @(negedge clk) begin
    if (ov_u) begin
      if (exp_u.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexp_u: out_valid with no frame expected");
      end else begin
        eu = exp_u.pop_front();
        last_u = eu;
        chk("u_val", val_u, eu.v);
        chk("u_idx", idx_u, eu.i);
        chk("u_mode", mode_u, eu.m);
        chk("u_rdy_done", rdy_u, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (ov_s) begin
      if (exp_s.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexp_s: out_valid with no frame expected");
      end else begin
        es = exp_s.pop_front();
        last_s = es;
        chk("s_val", val_s, es.v);
        chk("s_idx", idx_s, es.i);
        chk("s_mode", mode_s, es.m);
      end
    end
  end

  always @(negedge clk) begin
    if (ov1) begin
      if (exp_1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexp_1: out_valid with no sample expected");
      end else begin
        e1 = exp_1.pop_front();
        chk("f1_val", val1, e1.v);
        chk("f1_idx", idx1, 0);
        chk("f1_mode", mode1, e1.m);
        chk("f1_rdy_done", rdy1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic [7:0] d8;
    logic       m, r;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", rdy_u, 1);
    chk("rst_busy", busy_u, 0);
    chk("rst_val", val_u, 0);
    chk("rst_ov", ov_u, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Unsigned max, back to back.
    send(4'b1011, 0, 0); send(4'b1010, 0, 0); send(4'b1001, 0, 0); send(4'b0000, 0, 1);
    // Max then min over a mixed-sign frame.
    send(4'b0101, 0, 0); send(4'b1100, 0, 0); send(4'b1010, 0, 0); send(4'b0010, 0, 1);
    send(4'b0101, 1, 0); send(4'b1100, 0, 0); send(4'b1010, 0, 0); send(4'b0010, 0, 1);
    // Ties with idle gaps between samples.
    send(4'b0111, 0, 2); send(4'b0111, 0, 2); send(4'b0011, 0, 2); send(4'b0111, 0, 2);
    // Abort after two samples, then a full frame.
    send(4'b1110, 0, 0); send(4'b1111, 0, 0);
    do_clear();
    send(4'b0001, 0, 0); send(4'b1111, 0, 0); send(4'b0010, 0, 0); send(4'b0011, 0, 1);

    // Randomised frames with random gaps and random mid-frame aborts.
    for (int f = 0; f < 30; f++) begin
      m = 1'($urandom);
      for (int j = 0; j < FL; j++) begin
        d = 4'($urandom);
        send(d, (j == 0) ? m : 1'($urandom), $urandom_range(0, 2));
        if (j == 1 && $urandom_range(0, 5) == 0) begin
          do_clear();
          break;
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset partway through a frame.
    send(4'b1101, 0, 0); send(4'b0110, 0, 0); send(4'b1000, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    cur_q.delete();
    chk("arst_ready", rdy_u, 1);
    chk("arst_busy", busy_u, 0);
    chk("arst_val_u", val_u, 0);
    chk("arst_idx_u", idx_u, 0);
    chk("arst_mode_u", mode_u, 0);
    chk("arst_val_s", val_s, 0);
    chk("arst_ov", ov_u, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4'b0100, 1, 0); send(4'b0001, 0, 0); send(4'b0001, 0, 0); send(4'b1001, 0, 1);

    // One-sample frames with in_valid held high.
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      r  = rdy1;
      d8 = 8'($urandom);
      in_data1  = d8;
      mode_min1 = 1'($urandom);
      chk("f1_alternate", r, (k % 2 == 0));
      @(posedge clk);
      if (r) exp_1.push_back('{v: d8, i: 2'd0, m: mode_min1});
      #1;
    end
    in_valid1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("drain_u", exp_u.size(), 0);
    chk("drain_s", exp_s.size(), 0);
    chk("drain_1", exp_1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_extremum_finder.md
Name: stream_extremum_finder

Overview:
- Sequential, parametrised successor to the team's combinational two-input 4-bit maximum block.
- Scans a frame of FRAME_LEN samples arriving on a valid/ready stream and reports the frame's maximum or minimum value and the index where it first occurred.
- Supports unsigned or two's-complement comparison and per-frame max/min selection.
- Sits between a sample source and downstream logic that consumes one result per frame.

Parameters:
- WIDTH, 4, sample width in bits (>=1).
- FRAME_LEN, 4, samples per frame (>=1).
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned.
- IDX_W, (FRAME_LEN>1 ? $clog2(FRAME_LEN) : 1), width of the index output.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort of the frame in progress.
- mode_min  in  1  0 = find maximum, 1 = find minimum; sampled with the first sample of each frame.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  block accepts a sample this cycle.
- busy  out  1  a frame is partially accumulated.
- res_val  out  WIDTH  extremum of the last completed frame.
- res_idx  out  IDX_W  position (0-based) of res_val within that frame.
- res_mode  out  1  mode_min value used for the last completed frame.
- out_valid  out  1  one-cycle pulse: res_* updated.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears all registers. Outputs are in_ready=1, busy=0, res_val=0, res_idx=0, res_mode=0, out_valid=0.
- Accept: a sample is accepted when in_valid && in_ready at the clock edge. in_valid may drop for any number of cycles mid-frame; the frame simply pauses.
- States: IDLE, ACCUM, DONE.
- IDLE behaviour:
  - in_ready=1, busy=0.
  - On accept: best<=in_data, best_idx<=0, cnt<=1, mode_r<=mode_min.
  - Next state is ACCUM, or DONE directly if FRAME_LEN==1.
- ACCUM behaviour:
  - in_ready=1, busy=1.
  - On accept, compare in_data against best using SIGNED and mode_r.
  - Replace best/best_idx<=cnt only if strictly greater (max) or strictly less (min). Ties keep the earliest index.
  - cnt<=cnt+1.
  - When the accepted sample is index FRAME_LEN-1, go to DONE.
- DONE behaviour:
  - Lasts exactly one cycle; in_ready=0, busy=0.
  - res_val/res_idx/res_mode are registered on entry to DONE (visible during DONE).
  - out_valid=1 during DONE only, then return to IDLE.
  - Latency: out_valid rises on the edge following acceptance of the last sample.
  - Minimum frame period is FRAME_LEN+1 cycles.
- res_* hold their value until the next completed frame; reset is the only other thing that changes them.
- clear:
  - When high in IDLE or ACCUM: next state IDLE, cnt<=0, partial frame discarded, and any sample presented that cycle is not accepted.
  - res_* are unchanged and no out_valid is generated.
  - clear has priority over in_valid.
  - clear during DONE is ignored: that frame's result still publishes.
- mode_min changes after the first sample of a frame have no effect on that frame.
- Arithmetic:
  - Compare only, no arithmetic.
  - Signed compare uses $signed on both operands: -8 (4'b1000) < 7.
  - cnt is IDX_W+1 bits wide so that it never wraps within a frame.
- Reset mid-frame: the partial frame is lost and outputs take their reset values immediately, without waiting for a clock edge.

Test Plan (WIDTH=4, FRAME_LEN=4 unless noted):
1. Unsigned max: SIGNED=0, mode_min=0, samples 1011,1010,1001,0000 on back-to-back cycles -> out_valid one cycle after 4th accept; res_val=1011, res_idx=0; in_ready=0 in DONE cycle.
2. Signed max/min:
   - SIGNED=1, max, frame 0101,1100,1010,0010 -> res_val=0101, idx=0.
   - Same frame with mode_min=1 -> res_val=1010 (-6), idx=2.
   - Unsigned min on the same frame -> 0010, idx=3.
3. Ties and gaps: samples 0111,0111,0011,0111 with in_valid low for 2 cycles between each sample -> res_val=0111, res_idx=0, busy high throughout the gaps.
4. clear: after 2 samples, pulse clear together with in_valid=1 -> sample not accepted, busy=0, res_* keep the prior frame's values. A following full frame 0001,1111,0010,0011 (max) -> res_val=1111, idx=1.
5. Reset mid-frame: drop rst_n between edges after 3 samples -> all outputs at reset values without a clock edge. Release, send a full frame -> correct result with indices starting at 0.
6. FRAME_LEN=1, WIDTH=8: every accepted sample produces out_valid on the next edge with res_idx=0. in_valid held high -> accepts every other cycle (IDLE/DONE alternation).
